// File: rtl/counter_ctrl.sv
// Run/pause/stop controller for an external up-counter: clears it, enables it up to a
// terminal count, then either stops (one-shot) or reloads (auto-reload), counting periods.
module counter_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             oneshot,
   input  logic [WIDTH-1:0] period,
   input  logic [WIDTH-1:0] count_in,
   output logic             cnt_enable,
   output logic             cnt_clear,
   output logic             done,
   output logic             busy,
   output logic             err,
   output logic [7:0]       periods,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_RUN   = 2'd2,
      S_PAUSE = 2'd3
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] period_q;
   logic             mode_q;
   logic [7:0]       periods_q;
   logic             terminal;

   // A count beyond period_q is deliberately non-terminal; the controller never recovers it.
   assign terminal = (state_q == S_RUN) && (count_in == period_q);

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values; blocking here would create order-dependent simulation races.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         period_q  <= '0;
         mode_q    <= 1'b0;
         periods_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && !stop && (period != '0)) begin
                  period_q  <= period;
                  mode_q    <= oneshot;
                  periods_q <= '0;
                  state_q   <= S_CLEAR;
               end
            end
            S_CLEAR: state_q <= S_RUN;
            S_RUN: begin
               if (terminal) begin
                  periods_q <= periods_q + 8'd1;
                  if (mode_q)
                     state_q <= S_IDLE;
                  else if (stop)
                     state_q <= S_PAUSE;
               end else if (stop) begin
                  state_q <= S_PAUSE;
               end
            end
            S_PAUSE: begin
               if (stop)
                  state_q <= S_IDLE;
               else if (start)
                  state_q <= S_RUN;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // NOTE: every output gets a default before the case so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      cnt_enable = 1'b0;
      cnt_clear  = 1'b0;
      done       = 1'b0;
      err        = 1'b0;
      case (state_q)
         S_IDLE:  err = !reset && start && !stop && (period == '0);
         S_CLEAR: cnt_clear = 1'b1;
         S_RUN: begin
            if (terminal) begin
               done      = 1'b1;
               cnt_clear = !mode_q;
            end else begin
               cnt_enable = !stop;
            end
         end
         default: ;
      endcase
   end

   assign busy    = (state_q != S_IDLE);
   assign periods = periods_q;
   assign state   = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl: a behavioural counter closes the loop and each
// scenario task compares outputs against hand-derived values.
module tb_counter_ctrl;

   logic       clk;
   logic       reset;
   logic       start;
   logic       stop;
   logic       oneshot;
   logic [7:0] period;
   logic [7:0] count_q;
   logic       cnt_enable;
   logic       cnt_clear;
   logic       done;
   logic       busy;
   logic       err;
   logic [7:0] periods;
   logic [1:0] state;
   logic [6:0] outs;

   int vectors    = 0;
   int miscompares = 0;

   // Packed as {state[1:0], busy, cnt_enable, cnt_clear, done, err}.
   localparam logic [6:0] O_IDLE      = 7'b00_0_0_0_0_0;
   localparam logic [6:0] O_ERR       = 7'b00_0_0_0_0_1;
   localparam logic [6:0] O_CLEAR     = 7'b01_1_0_1_0_0;
   localparam logic [6:0] O_RUN_EN    = 7'b10_1_1_0_0_0;
   localparam logic [6:0] O_RUN_HOLD  = 7'b10_1_0_0_0_0;
   localparam logic [6:0] O_TERM_ONE  = 7'b10_1_0_0_1_0;
   localparam logic [6:0] O_TERM_AUTO = 7'b10_1_0_1_1_0;
   localparam logic [6:0] O_PAUSE     = 7'b11_1_0_0_0_0;

   counter_ctrl #(.WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .stop      (stop),
      .oneshot   (oneshot),
      .period    (period),
      .count_in  (count_q),
      .cnt_enable(cnt_enable),
      .cnt_clear (cnt_clear),
      .done      (done),
      .busy      (busy),
      .err       (err),
      .periods   (periods),
      .state     (state)
   );

   assign outs = {state, busy, cnt_enable, cnt_clear, done, err};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial count_q = 8'd0;
   always @(posedge clk) begin
      if (cnt_clear)
         count_q <= 8'd0;
      else if (cnt_enable)
         count_q <= count_q + 8'd1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic test_reset;
      reset = 1'b0; start = 1'b1; stop = 1'b0; oneshot = 1'b0; period = 8'd0;
      #1 reset = 1'b1;
      #1;
      vectors++; if (outs !== O_IDLE) begin miscompares++; $display("FAIL reset_outs: outs=%b expected=%b", outs, O_IDLE); end
      vectors++; if (periods !== 8'd0) begin miscompares++; $display("FAIL reset_periods: got %0d expected 0", periods); end
      @(negedge clk); reset = 1'b0; start = 1'b0; #1;
      vectors++; if (outs !== O_IDLE) begin miscompares++; $display("FAIL reset_release: outs=%b expected=%b", outs, O_IDLE); end
   endtask

   task automatic test_oneshot;
      logic [6:0] exp_o;
      @(negedge clk); start = 1'b1; oneshot = 1'b1; period = 8'd3; #1;
      vectors++; if (outs !== O_IDLE) begin miscompares++; $display("FAIL oneshot_start: outs=%b expected=%b", outs, O_IDLE); end
      @(negedge clk); start = 1'b0; oneshot = 1'b0; period = 8'd9; #1;
      vectors++; if (outs !== O_CLEAR) begin miscompares++; $display("FAIL oneshot_clear: outs=%b expected=%b", outs, O_CLEAR); end
      for (int c = 0; c <= 3; c++) begin
         @(negedge clk); #1;
         exp_o = (c < 3) ? O_RUN_EN : O_TERM_ONE;
         vectors++; if (count_q !== c[7:0]) begin miscompares++; $display("FAIL oneshot_count c=%0d: got %0d", c, count_q); end
         vectors++; if (outs !== exp_o) begin miscompares++; $display("FAIL oneshot_run c=%0d: outs=%b expected=%b", c, outs, exp_o); end
      end
      @(negedge clk); #1;
      vectors++; if (outs !== O_IDLE) begin miscompares++; $display("FAIL oneshot_end: outs=%b expected=%b", outs, O_IDLE); end
      vectors++; if (periods !== 8'd1) begin miscompares++; $display("FAIL oneshot_periods: got %0d expected 1", periods); end
      vectors++; if (count_q !== 8'd3) begin miscompares++; $display("FAIL oneshot_hold: got %0d expected 3", count_q); end
   endtask

   task automatic test_autoreload;
      logic [6:0] exp_o;
      @(negedge clk); start = 1'b1; oneshot = 1'b0; period = 8'd4;
      @(negedge clk); start = 1'b0; #1;
      vectors++; if (outs !== O_CLEAR) begin miscompares++; $display("FAIL auto_clear: outs=%b expected=%b", outs, O_CLEAR); end
      for (int p = 0; p < 3; p++) begin
         for (int c = 0; c <= 4; c++) begin
            @(negedge clk); #1;
            exp_o = (c < 4) ? O_RUN_EN : O_TERM_AUTO;
            vectors++; if (count_q !== c[7:0]) begin miscompares++; $display("FAIL auto_count p=%0d c=%0d: got %0d", p, c, count_q); end
            vectors++; if (outs !== exp_o) begin miscompares++; $display("FAIL auto_run p=%0d c=%0d: outs=%b expected=%b", p, c, outs, exp_o); end
            vectors++; if (periods !== p[7:0]) begin miscompares++; $display("FAIL auto_periods p=%0d: got %0d", p, periods); end
         end
      end
      @(negedge clk); stop = 1'b1; #1;
      vectors++; if (outs !== O_RUN_HOLD) begin miscompares++; $display("FAIL auto_stop: outs=%b expected=%b", outs, O_RUN_HOLD); end
      @(negedge clk); #1;
      vectors++; if (outs !== O_PAUSE) begin miscompares++; $display("FAIL auto_pause: outs=%b expected=%b", outs, O_PAUSE); end
      @(negedge clk); stop = 1'b0; #1;
      vectors++; if (outs !== O_IDLE) begin miscompares++; $display("FAIL auto_abort: outs=%b expected=%b", outs, O_IDLE); end
      vectors++; if (periods !== 8'd3) begin miscompares++; $display("FAIL auto_final_periods: got %0d expected 3", periods); end
   endtask

   task automatic test_pause_resume;
      logic [6:0] exp_o;
      @(negedge clk); start = 1'b1; oneshot = 1'b1; period = 8'd10;
      @(negedge clk); start = 1'b0; #1;
      vectors++; if (outs !== O_CLEAR) begin miscompares++; $display("FAIL pause_clear: outs=%b expected=%b", outs, O_CLEAR); end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); #1;
         vectors++; if (outs !== O_RUN_EN) begin miscompares++; $display("FAIL pause_pre c=%0d: outs=%b expected=%b", c, outs, O_RUN_EN); end
      end
      @(negedge clk); stop = 1'b1; #1;
      vectors++; if (outs !== O_RUN_HOLD) begin miscompares++; $display("FAIL pause_stop: outs=%b expected=%b", outs, O_RUN_HOLD); end
      for (int h = 0; h < 3; h++) begin
         @(negedge clk); stop = 1'b0; start = (h == 2); #1;
         vectors++; if (outs !== O_PAUSE) begin miscompares++; $display("FAIL pause_hold h=%0d: outs=%b expected=%b", h, outs, O_PAUSE); end
         vectors++; if (count_q !== 8'd5) begin miscompares++; $display("FAIL pause_count h=%0d: got %0d expected 5", h, count_q); end
      end
      for (int c = 5; c <= 10; c++) begin
         @(negedge clk); start = (c == 7); #1;
         exp_o = (c < 10) ? O_RUN_EN : O_TERM_ONE;
         vectors++; if (count_q !== c[7:0]) begin miscompares++; $display("FAIL resume_count c=%0d: got %0d", c, count_q); end
         vectors++; if (outs !== exp_o) begin miscompares++; $display("FAIL resume_run c=%0d: outs=%b expected=%b", c, outs, exp_o); end
      end
      @(negedge clk); start = 1'b0; #1;
      vectors++; if (outs !== O_IDLE) begin miscompares++; $display("FAIL resume_end: outs=%b expected=%b", outs, O_IDLE); end
      vectors++; if (periods !== 8'd1) begin miscompares++; $display("FAIL resume_periods: got %0d expected 1", periods); end
   endtask

   task automatic test_rejects;
      @(negedge clk); start = 1'b1; period = 8'd0; #1;
      vectors++; if (outs !== O_ERR) begin miscompares++; $display("FAIL reject_err: outs=%b expected=%b", outs, O_ERR); end
      @(negedge clk); start = 1'b0; #1;
      vectors++; if (outs !== O_IDLE) begin miscompares++; $display("FAIL reject_after: outs=%b expected=%b", outs, O_IDLE); end
      @(negedge clk); start = 1'b1; stop = 1'b1; period = 8'd5; #1;
      vectors++; if (outs !== O_IDLE) begin miscompares++; $display("FAIL reject_both: outs=%b expected=%b", outs, O_IDLE); end
      @(negedge clk); start = 1'b0; stop = 1'b0; #1;
      vectors++; if (outs !== O_IDLE) begin miscompares++; $display("FAIL reject_both_after: outs=%b expected=%b", outs, O_IDLE); end
      vectors++; if (periods !== 8'd1) begin miscompares++; $display("FAIL reject_periods: got %0d expected 1", periods); end
   endtask

   task automatic test_terminal_stop;
      @(negedge clk); start = 1'b1; oneshot = 1'b0; period = 8'd2;
      @(negedge clk); start = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk); #1;
         vectors++; if (outs !== O_RUN_EN) begin miscompares++; $display("FAIL tstop_run c=%0d: outs=%b expected=%b", c, outs, O_RUN_EN); end
      end
      @(negedge clk); stop = 1'b1; #1;
      vectors++; if (outs !== O_TERM_AUTO) begin miscompares++; $display("FAIL tstop_term: outs=%b expected=%b", outs, O_TERM_AUTO); end
      @(negedge clk); stop = 1'b0; #1;
      vectors++; if (outs !== O_PAUSE) begin miscompares++; $display("FAIL tstop_pause: outs=%b expected=%b", outs, O_PAUSE); end
      vectors++; if (count_q !== 8'd0) begin miscompares++; $display("FAIL tstop_count: got %0d expected 0", count_q); end
      vectors++; if (periods !== 8'd1) begin miscompares++; $display("FAIL tstop_periods: got %0d expected 1", periods); end
      @(negedge clk); stop = 1'b1; start = 1'b1; #1;
      vectors++; if (outs !== O_PAUSE) begin miscompares++; $display("FAIL tstop_priority: outs=%b expected=%b", outs, O_PAUSE); end
      @(negedge clk); stop = 1'b0; start = 1'b0; #1;
      vectors++; if (outs !== O_IDLE) begin miscompares++; $display("FAIL tstop_abort: outs=%b expected=%b", outs, O_IDLE); end
   endtask

   task automatic test_wrap;
      logic [7:0] exp_periods;
      int         zero_seen;
      int         done_seen;
      exp_periods = 8'd0; zero_seen = 0; done_seen = 0;
      @(negedge clk); start = 1'b1; oneshot = 1'b0; period = 8'd1;
      @(negedge clk); start = 1'b0; #1;
      vectors++; if (outs !== O_CLEAR) begin miscompares++; $display("FAIL wrap_clear: outs=%b expected=%b", outs, O_CLEAR); end
      for (int k = 0; k < 512; k++) begin
         @(negedge clk); #1;
         if (k > 0 && periods === 8'd0) zero_seen++;
         vectors++; if (outs !== O_RUN_EN) begin miscompares++; $display("FAIL wrap_run k=%0d: outs=%b expected=%b", k, outs, O_RUN_EN); end
         @(negedge clk); #1;
         if (done === 1'b1) done_seen++;
         vectors++; if (outs !== O_TERM_AUTO) begin miscompares++; $display("FAIL wrap_term k=%0d: outs=%b expected=%b", k, outs, O_TERM_AUTO); end
         vectors++; if (periods !== exp_periods) begin miscompares++; $display("FAIL wrap_periods k=%0d: got %0d expected %0d", k, periods, exp_periods); end
         exp_periods = exp_periods + 8'd1;
      end
      @(negedge clk); stop = 1'b1; #1;
      if (periods === 8'd0) zero_seen++;
      vectors++; if (periods !== 8'd0) begin miscompares++; $display("FAIL wrap_final: got %0d expected 0", periods); end
      vectors++; if (zero_seen !== 2) begin miscompares++; $display("FAIL wrap_zero_returns: got %0d expected 2", zero_seen); end
      vectors++; if (done_seen !== 512) begin miscompares++; $display("FAIL wrap_done_count: got %0d expected 512", done_seen); end
      @(negedge clk);
      @(negedge clk); stop = 1'b0; #1;
      vectors++; if (outs !== O_IDLE) begin miscompares++; $display("FAIL wrap_exit: outs=%b expected=%b", outs, O_IDLE); end
   endtask

   task automatic test_async_reset;
      logic [6:0] exp_o;
      @(negedge clk); start = 1'b1; oneshot = 1'b0; period = 8'd2;
      @(negedge clk); start = 1'b0;
      for (int c = 0; c < 4; c++) @(negedge clk);
      #1;
      vectors++; if (outs !== O_RUN_EN) begin miscompares++; $display("FAIL areset_pre: outs=%b expected=%b", outs, O_RUN_EN); end
      vectors++; if (periods !== 8'd1) begin miscompares++; $display("FAIL areset_pre_periods: got %0d expected 1", periods); end
      #2 reset = 1'b1;
      #1;
      vectors++; if (outs !== O_IDLE) begin miscompares++; $display("FAIL areset_async: outs=%b expected=%b", outs, O_IDLE); end
      vectors++; if (periods !== 8'd0) begin miscompares++; $display("FAIL areset_periods: got %0d expected 0", periods); end
      @(negedge clk); #1;
      vectors++; if (outs !== O_IDLE) begin miscompares++; $display("FAIL areset_held: outs=%b expected=%b", outs, O_IDLE); end
      @(negedge clk); reset = 1'b0; start = 1'b1; oneshot = 1'b1; period = 8'd2;
      @(negedge clk); start = 1'b0; #1;
      vectors++; if (outs !== O_CLEAR) begin miscompares++; $display("FAIL areset_restart: outs=%b expected=%b", outs, O_CLEAR); end
      for (int c = 0; c <= 2; c++) begin
         @(negedge clk); #1;
         exp_o = (c < 2) ? O_RUN_EN : O_TERM_ONE;
         vectors++; if (count_q !== c[7:0]) begin miscompares++; $display("FAIL areset_count c=%0d: got %0d", c, count_q); end
         vectors++; if (outs !== exp_o) begin miscompares++; $display("FAIL areset_run c=%0d: outs=%b expected=%b", c, outs, exp_o); end
      end
      @(negedge clk); #1;
      vectors++; if (outs !== O_IDLE) begin miscompares++; $display("FAIL areset_end: outs=%b expected=%b", outs, O_IDLE); end
      vectors++; if (periods !== 8'd1) begin miscompares++; $display("FAIL areset_end_periods: got %0d expected 1", periods); end
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_autoreload();
      test_pause_resume();
      test_rejects();
      test_terminal_stop();
      test_wrap();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, width of the controlled counter's count and of the period.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  level-sampled request: begin a run (IDLE) or resume (PAUSE).
REQ-005 stop  input  1  level-sampled request: pause (RUN) or abort (PAUSE).
REQ-006 oneshot  input  1  sampled with start in IDLE; 1 = single period, 0 = auto-reload.
REQ-007 period  input  WIDTH  terminal count, sampled with start in IDLE.
REQ-008 count_in  input  WIDTH  current count of the controlled counter.
REQ-009 cnt_enable  output  1  drives the counter's enable.
REQ-010 cnt_clear  output  1  drives the counter's reset; counter is 0 on the cycle after it is sampled high.
REQ-011 done  output  1  one-cycle pulse at each terminal count.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 err  output  1  one-cycle pulse on a rejected start.
REQ-014 periods  output  8  completed-period count, modulo 256.
REQ-015 state  output  2  encoding IDLE=0, CLEAR=1, RUN=2, PAUSE=3.

Function
REQ-016 FSM states: IDLE, CLEAR, RUN, PAUSE; outputs decoded from the state register, period_reg, mode_reg and count_in.
REQ-017 IDLE: cnt_enable=0, cnt_clear=0; start=1, stop=0 and period!=0 -> latch period_reg<=period, mode_reg<=oneshot, periods<=0, go CLEAR.
REQ-018 IDLE with start=1 and period=0: err=1 for that cycle, stay IDLE, period_reg/mode_reg unchanged.
REQ-019 IDLE with start=1 and stop=1: stop wins, stay IDLE, no err.
REQ-020 CLEAR: cnt_clear=1, cnt_enable=0 for exactly one cycle, then RUN unconditionally.
REQ-021 RUN, non-terminal cycle (count_in!=period_reg): cnt_enable=1, cnt_clear=0.
REQ-022 RUN terminal cycle (count_in==period_reg): done=1, cnt_enable=0, periods increments (wraps 255->0).
REQ-023 Terminal, mode_reg=1: next state IDLE, cnt_clear=0 (final count held in counter).
REQ-024 Terminal, mode_reg=0: cnt_clear=1 same cycle, stay RUN; RUN interval per period = period_reg+1 cycles (counts 0..period_reg).
REQ-025 RUN with stop=1 (non-terminal cycle): cnt_enable=0 that cycle, go PAUSE; count preserved.
REQ-026 Terminal cycle with stop=1: terminal action (done, periods, clear or IDLE) completes; then PAUSE if mode_reg=0, IDLE if mode_reg=1.
REQ-027 PAUSE: cnt_enable=0, cnt_clear=0; stop=1 -> IDLE; else start=1 -> RUN; else hold. stop has priority.
REQ-028 start in RUN/CLEAR and oneshot/period changes while busy: ignored.
REQ-029 count_in>period_reg in RUN (external disturbance): treated as non-terminal; no saturation or recovery by the controller.
REQ-030 busy=1 in CLEAR, RUN, PAUSE; done and err never high simultaneously.

Reset
REQ-031 reset=1 forces, asynchronously: state=IDLE, period_reg=0, mode_reg=0, periods=0; cnt_enable=0, cnt_clear=0, done=0, err=0, busy=0.
REQ-032 Reset mid-run aborts immediately; no done pulse is issued for the aborted period; first start after release behaves as from power-up.

Verification
REQ-033 Oneshot: period=3, oneshot=1, start 1 cycle -> CLEAR 1 cycle, RUN with count 0,1,2,3, done=1 at count 3, then IDLE, busy=0, periods=1.
REQ-034 Auto-reload: period=4, oneshot=0 -> done every 5 cycles; after 3 pulses periods=3; counter seen 0..4 repeating.
REQ-035 Pause/resume: period=10, stop at count 5 -> cnt_enable=0, count holds 5 for 4 cycles; start -> resumes 6..10, done at 10.
REQ-036 Rejects: start with period=0 -> err pulse, state stays 0; start and stop together in IDLE -> no state change, no err.
REQ-037 Wrap: period=1, oneshot=0, run 512 periods -> periods returns to 0 twice; no missed done pulses.
REQ-038 Async reset: assert reset mid-RUN between clock edges -> all outputs 0 before the next edge; restart with period=2 -> done at count 2.
